// File: rtl/stream_narrow_if.sv
// rtl/stream_narrow_if.sv - handshake bundle for the stream_narrow width down-converter
//
// Ports carried:
//   valid_i / ready_i / data_i / len_i   wide input word (RATIO sub-words of WIDTH bits, beat count)
//   valid_o / ready_o / data_o / idx_o   narrow output beat and its position in the group
//   last_o / tag_i / tag_o               only when STREAM_NARROW_LAST_EN is defined
// Modports: master = producer/consumer side, slave = the narrower itself.
interface stream_narrow_if #(
    parameter int WIDTH = 64,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
`ifdef STREAM_NARROW_LAST_EN
    ,
    parameter int TAGW  = 8
`endif
);
    logic                   valid_i;
    logic                   ready_i;
    logic [WIDTH*RATIO-1:0] data_i;
    logic [CW-1:0]          len_i;
    logic                   valid_o;
    logic                   ready_o;
    logic [WIDTH-1:0]       data_o;
    logic [CW-1:0]          idx_o;
`ifdef STREAM_NARROW_LAST_EN
    logic                   last_o;
    logic [TAGW-1:0]        tag_i;
    logic [TAGW-1:0]        tag_o;
`endif

    modport master (
        output valid_i, data_i, len_i, ready_o,
`ifdef STREAM_NARROW_LAST_EN
        output tag_i,
        input  last_o, tag_o,
`endif
        input  ready_i, valid_o, data_o, idx_o
    );

    modport slave (
        input  valid_i, data_i, len_i, ready_o,
`ifdef STREAM_NARROW_LAST_EN
        input  tag_i,
        output last_o, tag_o,
`endif
        output ready_i, valid_o, data_o, idx_o
    );
endinterface

// File: rtl/stream_narrow.sv
// rtl/stream_narrow.sv - width down-converter: one wide word in, up to RATIO sub-words out
//
// Ports:
//   clk   clock
//   rstN  asynchronous active-low reset
//   s     stream_narrow_if.slave (input word valid/ready/data/len, output beat valid/ready/data/idx)
// Optional: define STREAM_NARROW_LAST_EN to add last_o and a tag_i -> tag_o passthrough.
module stream_narrow #(
    parameter int WIDTH     = 64,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 0,
    parameter int CW        = $clog2(RATIO + 1)
`ifdef STREAM_NARROW_LAST_EN
    ,
    parameter int TAGW      = 8
`endif
) (
    input  logic           clk,
    input  logic           rstN,
    stream_narrow_if.slave s
);
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [CW-1:0]          len_hold, len_eff, sel;
    logic [WIDTH*RATIO-1:0] data_hold;
    logic [WIDTH-1:0]       data_sel;
    logic                   valid_hold, last, load, accept;
`ifdef STREAM_NARROW_LAST_EN
    logic [TAGW-1:0]        tag_hold;
`endif

    // Out-of-range counts are folded to a full group so cnt can never run past RATIO-1.
    assign len_eff    = (s.len_i == '0 || s.len_i > RATIO_C) ? RATIO_C : s.len_i;
    assign valid_hold = (state == EMIT);
    assign last       = valid_hold && (cnt == len_hold - CW'(1));
    // Only the final beat of a group lets ready_o through to the upstream side.
    assign s.ready_i  = !valid_hold || (last && s.ready_o);
    assign accept     = s.valid_i && s.ready_i;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (s.ready_o) begin
                    if (!last) begin
                        cnt_d = cnt + CW'(1);
                    end else begin
                        cnt_d = '0;
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            cnt       <= '0;
            len_hold  <= '0;
            data_hold <= '0;
`ifdef STREAM_NARROW_LAST_EN
            tag_hold  <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                len_hold  <= len_eff;
                data_hold <= s.data_i;
`ifdef STREAM_NARROW_LAST_EN
                tag_hold  <= s.tag_i;
`endif
            end
        end
    end

    // Emission order is a pure relabelling of cnt; idx_o always counts up from 0.
    assign sel = (MSB_FIRST != 0) ? (RATIO_C - CW'(1) - cnt) : cnt;

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == sel) begin
                data_sel = data_hold[k*WIDTH +: WIDTH];
            end
        end
    end

    assign s.valid_o = valid_hold;
    assign s.data_o  = data_sel;
    assign s.idx_o   = cnt;
`ifdef STREAM_NARROW_LAST_EN
    assign s.last_o  = last;
    assign s.tag_o   = tag_hold;
`endif

    len_legal: assert property (@(posedge clk) disable iff (!rstN)
        (s.valid_i && s.ready_i) |-> (s.len_i != '0 && s.len_i <= RATIO_C));
endmodule
